// File: rtl/axi_pkg.sv
// Shared AXI types for the burst address generator: burst/response encodings,
// field widths and the latched address-channel request.
package axi_pkg;

  localparam int unsigned AXI_ADDR_WIDTH    = 32;
  localparam int unsigned AXI_LEN_WIDTH     = 8;
  localparam int unsigned AXI_SIZE_WIDTH    = 3;
  localparam int unsigned AXI_LEN_MAX_BYTES = 4096;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10,
    AXI_BURST_RSVD  = 2'b11
  } axi_burst_e;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [AXI_LEN_WIDTH-1:0]  len;
    logic [AXI_SIZE_WIDTH-1:0] size;
    axi_burst_e                burst;
  } axi_ax_req_t;

  typedef enum logic {StIdle, StActive} gen_state_e;

endpackage

// File: rtl/axi_strb_gen.sv
// Combinational byte-lane strobe for one beat: lanes from the (possibly unaligned)
// address up to the end of the size-aligned container.
module axi_strb_gen
  import axi_pkg::*;
#(
  parameter int unsigned DW = 32,
  localparam int unsigned NB = DW / 8,
  localparam int unsigned LW = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic [LW-1:0]             addr_lo,
  input  logic [AXI_SIZE_WIDTH-1:0] size,
  output logic [NB-1:0]             strb
);

  int unsigned lo, hi, nbytes;

  always_comb begin
    lo     = 32'(addr_lo) & (NB - 1);
    nbytes = 32'd1 << size;
    hi     = (lo & ~(nbytes - 1)) + nbytes - 1;
    strb   = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      strb[i] = (i >= lo) && (i <= hi);
    end
  end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// Expands one AXI AR/AW request into per-beat address, strobe, index, last and response.
// Optional 4 KB page-crossing check for INCR bursts: define AXI_ADDR_GEN_4K_CHECK_EN.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int unsigned AW = AXI_ADDR_WIDTH,  // struct addr field is AXI_ADDR_WIDTH wide
  parameter int unsigned DW = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [AW-1:0]             req_addr,
  input  logic [AXI_LEN_WIDTH-1:0]  req_len,
  input  logic [AXI_SIZE_WIDTH-1:0] req_size,
  input  logic [1:0]                req_burst,
  output logic                      beat_valid,
  input  logic                      beat_ready,
  output logic [AW-1:0]             beat_addr,
  output logic [DW/8-1:0]           beat_strb,
  output logic [AXI_LEN_WIDTH-1:0]  beat_idx,
  output logic                      beat_last,
  output logic [1:0]                beat_resp,
  output logic                      busy
);

  localparam int unsigned NB       = DW / 8;
  localparam int unsigned LW       = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned MAX_SIZE = $clog2(NB);

  gen_state_e               state_q, state_d;
  axi_ax_req_t              req_q, req_d;
  logic [AW-1:0]            addr_q, addr_d, mask_q, mask_d;
  logic [AXI_LEN_WIDTH-1:0] idx_q, idx_d;
  logic                     err_q, err_d;

  logic          beat_fire, last_fire, accept, req_err, page_cross;
  logic [AW-1:0] size_bytes, total_bytes, beat_bytes, cur_inc, next_addr;
  logic [NB-1:0] strb_raw;

  assign beat_valid = (state_q == StActive);
  assign busy       = beat_valid;
  assign beat_last  = beat_valid && (idx_q == req_q.len);
  assign beat_fire  = beat_valid && beat_ready;
  assign last_fire  = beat_fire && beat_last;
  assign req_ready  = !rst && ((state_q == StIdle) || last_fire);
  assign accept     = req_valid && req_ready;

  assign beat_addr = beat_valid ? addr_q : '0;
  assign beat_idx  = beat_valid ? idx_q : '0;
  assign beat_strb = (beat_valid && !err_q) ? strb_raw : '0;
  assign beat_resp = (beat_valid && err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

  axi_strb_gen #(
    .DW(DW)
  ) u_strb_gen (
    .addr_lo(addr_q[LW-1:0]),
    .size   (req_q.size),
    .strb   (strb_raw)
  );

  assign size_bytes  = AW'(1) << req_size;
  assign total_bytes = (AW'(req_len) + AW'(1)) << req_size;

`ifdef AXI_ADDR_GEN_4K_CHECK_EN
  localparam int unsigned PB = $clog2(AXI_LEN_MAX_BYTES);
  logic [AW:0] last_byte;
  // One extra bit so a burst running off the top of the address space also counts as crossing.
  assign last_byte  = {1'b0, req_addr & ~(size_bytes - AW'(1))} + {1'b0, total_bytes}
                      - {{AW{1'b0}}, 1'b1};
  assign page_cross = (last_byte[AW:PB] != {1'b0, req_addr[AW-1:PB]});
`else
  assign page_cross = 1'b0;
`endif

  always_comb begin
    req_err = 1'b0;
    if (axi_burst_e'(req_burst) == AXI_BURST_RSVD) req_err = 1'b1;
    if (32'(req_size) > MAX_SIZE) req_err = 1'b1;
    if (axi_burst_e'(req_burst) == AXI_BURST_WRAP) begin
      if (!(req_len inside {8'd1, 8'd3, 8'd7, 8'd15})) req_err = 1'b1;
      if ((req_addr & (size_bytes - AW'(1))) != '0) req_err = 1'b1;
    end
    if ((axi_burst_e'(req_burst) == AXI_BURST_INCR) && page_cross) req_err = 1'b1;
  end

  // Wrap bursts keep the bits above the wrap window and roll the bits inside it.
  assign beat_bytes = AW'(1) << req_q.size;
  assign cur_inc    = (addr_q & ~(beat_bytes - AW'(1))) + beat_bytes;

  always_comb begin
    next_addr = cur_inc;
    if (err_q) begin
      next_addr = req_q.addr;
    end else begin
      case (req_q.burst)
        AXI_BURST_FIXED: next_addr = req_q.addr;
        AXI_BURST_WRAP:  next_addr = (addr_q & ~mask_q) | (cur_inc & mask_q);
        default:         next_addr = cur_inc;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    err_d   = err_q;
    if (beat_fire && !beat_last) begin
      addr_d = next_addr;
      idx_d  = idx_q + 8'd1;
    end
    if (last_fire) state_d = StIdle;
    if (accept) begin
      state_d = StActive;
      req_d   = '{addr: req_addr, len: req_len, size: req_size, burst: axi_burst_e'(req_burst)};
      addr_d  = req_addr;
      idx_d   = '0;
      err_d   = req_err;
      mask_d  = total_bytes - AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      req_q   <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Scoreboard bench for axi_burst_addr_gen (DW=32): expected beats come from a burst model.
module tb_axi_burst_addr_gen;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [7:0]  idx;
    logic        last;
    logic [1:0]  resp;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [7:0]  req_len = '0;
  logic [2:0]  req_size = '0;
  logic [1:0]  req_burst = '0;
  logic        beat_valid;
  logic        beat_ready = 1'b1;
  logic [31:0] beat_addr;
  logic [3:0]  beat_strb;
  logic [7:0]  beat_idx;
  logic        beat_last;
  logic [1:0]  beat_resp;
  logic        busy;

  int    total = 0;
  int    bad = 0;
  beat_t sb[$];

  always #5 clk = ~clk;

  axi_burst_addr_gen #(
    .AW(32),
    .DW(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_size  (req_size),
    .req_burst (req_burst),
    .beat_valid(beat_valid),
    .beat_ready(beat_ready),
    .beat_addr (beat_addr),
    .beat_strb (beat_strb),
    .beat_idx  (beat_idx),
    .beat_last (beat_last),
    .beat_resp (beat_resp),
    .busy      (busy)
  );

  function automatic beat_t sample();
    return beat_t'{beat_addr, beat_strb, beat_idx, beat_last, beat_resp};
  endfunction

  // Reference model built from the burst rules, pushing one entry per beat.
  task automatic push_expected(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                               input logic [1:0] b);
    logic [31:0] sz, t, base, ba, lo, hi;
    logic [32:0] lastb;
    logic [3:0]  st;
    bit          err;
    sz  = 32'd1 << s;
    t   = (32'(l) + 1) * sz;
    err = (b == 2'b11) || (sz > 4) || ((b == 2'b10) && !(l inside {1, 3, 7, 15})) ||
          ((b == 2'b10) && (a % sz != 0));
`ifdef AXI_ADDR_GEN_4K_CHECK_EN
    lastb = {1'b0, a & ~(sz - 1)} + {1'b0, t} - 33'd1;
    if ((b == 2'b01) && (lastb[32:12] != {1'b0, a[31:12]})) err = 1'b1;
`else
    lastb = '0;
`endif
    for (int n = 0; n <= int'(l); n++) begin
      if (err || b == 2'b00 || n == 0) ba = a;
      else if (b == 2'b01) ba = (a & ~(sz - 1)) + 32'(n) * sz;
      else begin
        base = a - (a % t);
        ba   = base + ((a - base + 32'(n) * sz) % t);
      end
      lo = ba % 4;
      hi = ((ba & ~(sz - 1)) % 4) + sz - 1;
      st = '0;
      for (int i = 0; i < 4; i++) st[i] = !err && (32'(i) >= lo) && (32'(i) <= hi);
      sb.push_back(beat_t'{ba, st, 8'(n), n == int'(l), err ? 2'b10 : 2'b00});
    end
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic send_req(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b, output bit ok);
    req_addr = a; req_len = l; req_size = s; req_burst = b; req_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (sample() !== '0 || beat_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_outputs: got %p valid=%b busy=%b want all zero",
                      sample(), beat_valid, busy);
    end
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_ready: got ready=%b busy=%b want 1 0", req_ready, busy);
    end
  endtask

  // Table of independent requests, each drained through the scoreboard.
  task automatic run_table(input string name, input logic [31:0] ta[], input logic [7:0] tl[],
                           input logic [2:0] ts[], input logic [1:0] tb[]);
    bit ok, done;
    beat_t obs, exp;
    for (int r = 0; r < ta.size(); r++) begin
      push_expected(ta[r], tl[r], ts[r], tb[r]);
      send_req(ta[r], tl[r], ts[r], tb[r], ok);
      total++;
      if (!ok) begin bad++; $display("FAIL %s accept[%0d]: got ready=0 want 1", name, r); end
      done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
        @(negedge clk);
        if (beat_valid) begin
          obs = sample();
          total++;
          if (sb.size() == 0) begin
            bad++; $display("FAIL %s extra_beat: got %p want none", name, obs);
          end else begin
            exp = sb.pop_front();
            if (obs !== exp) begin bad++; $display("FAIL %s beat: got %p want %p", name, obs, exp); end
          end
          done = obs.last;
        end
      end
      total++;
      if (!done || sb.size() != 0) begin
        bad++; $display("FAIL %s drain[%0d]: got done=%b left=%0d want 1 0", name, r, done, sb.size());
        sb.delete();
      end
    end
  endtask

  task automatic test_incr();
    run_table("incr", '{32'h1002, 32'h0FF8}, '{8'd3, 8'd3}, '{3'd2, 3'd2}, '{2'b01, 2'b01});
  endtask

  task automatic test_wrap();
    run_table("wrap", '{32'h1034, 32'h2008}, '{8'd3, 8'd7}, '{3'd2, 3'd1}, '{2'b10, 2'b10});
  endtask

  task automatic test_illegal();
    run_table("illegal", '{32'h5003, 32'h6000, 32'h7000}, '{8'd1, 8'd2, 8'd0},
              '{3'd0, 3'd2, 3'd3}, '{2'b11, 2'b10, 2'b01});
  endtask

  task automatic test_back_to_back();
    bit ok, done, second, gap;
    beat_t obs, exp;
    push_expected(32'h2001, 8'd2, 3'd0, 2'b00);
    push_expected(32'h0, 8'd0, 3'd2, 2'b01);
    send_req(32'h2001, 8'd2, 3'd0, 2'b00, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL b2b accept: got ready=0 want 1"); end
    done = 1'b0; second = 1'b0; gap = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (gap) begin
        req_valid = 1'b0;
        gap = 1'b0;
        total++;
        if (beat_valid !== 1'b1) begin bad++; $display("FAIL b2b no_gap: got valid=%b want 1", beat_valid); end
      end
      if (beat_valid) begin
        obs = sample();
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL b2b extra_beat: got %p want none", obs);
        end else begin
          exp = sb.pop_front();
          if (obs !== exp) begin bad++; $display("FAIL b2b beat: got %p want %p", obs, exp); end
        end
        if (obs.last && !second) begin
          req_addr = 32'h0; req_len = 8'd0; req_size = 3'd2; req_burst = 2'b01; req_valid = 1'b1;
          second = 1'b1; gap = 1'b1;
          total++;
          if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b ready_on_last: got %b want 1", req_ready); end
        end else if (obs.last) begin
          done = 1'b1;
        end
      end
    end
    req_valid = 1'b0;
    total++;
    if (!done || sb.size() != 0) begin
      bad++; $display("FAIL b2b drain: got done=%b left=%0d want 1 0", done, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_stall_reset();
    bit ok, hit;
    beat_t obs, exp;
    push_expected(32'h3000, 8'd7, 3'd2, 2'b01);
    send_req(32'h3000, 8'd7, 3'd2, 2'b01, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL stall accept: got ready=0 want 1"); end
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      if (beat_valid) begin
        obs = sample();
        exp = sb.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL stall beat: got %p want %p", obs, exp); end
        if (obs.idx == 8'd2) begin
          beat_ready = 1'b0;
          for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            total++;
            if (sample() !== obs || beat_valid !== 1'b1) begin
              bad++; $display("FAIL stall hold[%0d]: got %p want %p", h, sample(), obs);
            end
          end
          beat_ready = 1'b1;
        end
        if (obs.idx == 8'd4) begin
          rst = 1'b1;
          hit = 1'b1;
        end
      end
    end
    total++;
    if (!hit) begin bad++; $display("FAIL stall reach_beat4: got 0 want 1"); end
    @(negedge clk);
    total++;
    if (beat_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0) begin
      bad++; $display("FAIL mid_reset: got valid=%b busy=%b ready=%b want 0 0 0",
                      beat_valid, busy, req_ready);
    end
    sb.delete();
    rst = 1'b0;
    run_table("post_reset", '{32'h0040}, '{8'd1}, '{3'd2}, '{2'b01});
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_back_to_back();
    test_illegal();
    test_stall_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
